fxp_divider: RTL and testbench



---
 rtl/fxp_div_pkg.sv | 22 ++
 rtl/fxp_div_round.sv | 53 +++++
 rtl/fxp_divider.sv | 167 ++++++++++++++++
 tb/tb_fxp_divider.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fxp_div_pkg.sv
// Shared types and sizing helpers for the sequential fixed-point divider.
package fxp_div_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_ROUND,
      ST_DONE
   } state_t;

   localparam logic RND_TRUNC = 1'b0;
   localparam logic RND_RNE   = 1'b1;

   function automatic int unsigned div_iters(input int unsigned width, input int unsigned fbits);
      return width + fbits + 1;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned width, input int unsigned fbits);
      return $clog2(div_iters(width, fbits) + 1);
   endfunction

endpackage

// File: rtl/fxp_div_round.sv
// Round, limit-check and sign-apply stage for the raw quotient (one guard bit at q[0]).
module fxp_div_round
   import fxp_div_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned FBITS = 16
) (
   input  logic [WIDTH+FBITS:0] q,
   input  logic                 rem_nz,
   input  logic                 is_signed,
   input  logic                 neg_sign,
   input  logic                 rnd,
   input  logic                 sat,
   output logic [WIDTH-1:0]     val_c,
   output logic                 ovf_c,
   output logic                 inexact_c
);

   localparam int unsigned N = WIDTH + FBITS + 1;
   localparam logic [N-1:0] LIM_U  = (N'(1) << WIDTH) - N'(1);
   localparam logic [N-1:0] LIM_SP = (N'(1) << (WIDTH - 1)) - N'(1);
   localparam logic [N-1:0] LIM_SN = N'(1) << (WIDTH - 1);

   logic [N-1:0] mag_raw;
   logic [N-1:0] mag;
   logic [N-1:0] mag_neg;
   logic [N-1:0] lim;
   logic         half;
   logic         inc;
   logic         neg;

   always_comb begin
      mag_raw   = {1'b0, q[N-1:1]};
      half      = q[0];
      inc       = (rnd == RND_RNE) && half && (rem_nz || mag_raw[0]);
      mag       = mag_raw + N'(inc);
      mag_neg   = -mag;
      inexact_c = half | rem_nz;
      neg       = is_signed && neg_sign && (mag != '0);
      if (!is_signed)
         lim = LIM_U;
      else if (neg)
         lim = LIM_SN;
      else
         lim = LIM_SP;
      ovf_c = (mag > lim);
      if (ovf_c)
         val_c = sat ? lim[WIDTH-1:0] : '0;
      else
         val_c = neg ? mag_neg[WIDTH-1:0] : mag[WIDTH-1:0];
   end

endmodule

// File: rtl/fxp_divider.sv
// Sequential QI.F divider: val = (a << FBITS) / b, one restoring-division quotient bit per clock.
module fxp_divider
   import fxp_div_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned FBITS = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_signed,
   input  logic             rnd,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] val,
   output logic             dbz,
   output logic             ovf,
   output logic             inexact
);

   localparam int unsigned N  = div_iters(WIDTH, FBITS);
   localparam int unsigned CW = cnt_width(WIDTH, FBITS);

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [N-1:0]     qr;
   logic [WIDTH:0]   acc;
   logic [WIDTH:0]   acc_sh;
   logic [WIDTH:0]   acc_nxt;
   logic             q_bit;
   logic [WIDTH-1:0] bmag;
   logic [WIDTH-1:0] amag_c;
   logic [WIDTH-1:0] bmag_c;
   logic [WIDTH-1:0] dbz_val_c;
   logic             sign_a, sign_b;
   logic             is_signed_q, rnd_q, sat_q;
   logic             accept;
   logic             last_iter;
   logic [WIDTH-1:0] r_val;
   logic             r_ovf, r_inexact;

   assign in_ready = (state == ST_IDLE);

   // Operand magnitudes; the most-negative value maps onto 2^(WIDTH-1) naturally.
   always_comb begin
      amag_c = (is_signed && a[WIDTH-1]) ? -a : a;
      bmag_c = (is_signed && b[WIDTH-1]) ? -b : b;
      if ((a == '0) || !sat)
         dbz_val_c = '0;
      else if (!is_signed)
         dbz_val_c = '1;
      else if (a[WIDTH-1])
         dbz_val_c = {1'b1, {(WIDTH-1){1'b0}}};
      else
         dbz_val_c = {1'b0, {(WIDTH-1){1'b1}}};
   end

   // Restoring step: dividend bits leave qr's MSB, quotient bits enter its LSB.
   always_comb begin
      acc_sh  = {acc[WIDTH-1:0], qr[N-1]};
      q_bit   = (acc_sh >= {1'b0, bmag});
      acc_nxt = q_bit ? (acc_sh - {1'b0, bmag}) : acc_sh;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last_iter = (cnt == CW'(N - 1));
      case (state)
         ST_IDLE: begin
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = (b == '0) ? ST_DONE : ST_CALC;
            end
         end
         ST_CALC:  if (last_iter) state_nxt = ST_ROUND;
         ST_ROUND: state_nxt = ST_DONE;
         ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         qr          <= '0;
         acc         <= '0;
         bmag        <= '0;
         sign_a      <= 1'b0;
         sign_b      <= 1'b0;
         is_signed_q <= 1'b0;
         rnd_q       <= RND_TRUNC;
         sat_q       <= 1'b0;
         out_valid   <= 1'b0;
         val         <= '0;
         dbz         <= 1'b0;
         ovf         <= 1'b0;
         inexact     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  is_signed_q <= is_signed;
                  rnd_q       <= rnd;
                  sat_q       <= sat;
                  sign_a      <= is_signed & a[WIDTH-1];
                  sign_b      <= is_signed & b[WIDTH-1];
                  bmag        <= bmag_c;
                  qr          <= N'(amag_c) << (FBITS + 1);
                  acc         <= '0;
                  cnt         <= '0;
                  ovf         <= 1'b0;
                  inexact     <= 1'b0;
                  if (b == '0) begin
                     val       <= dbz_val_c;
                     dbz       <= 1'b1;
                     out_valid <= 1'b1;
                  end else begin
                     dbz <= 1'b0;
                  end
               end
            end
            ST_CALC: begin
               acc <= acc_nxt;
               qr  <= {qr[N-2:0], q_bit};
               cnt <= cnt + CW'(1);
            end
            ST_ROUND: begin
               val       <= r_val;
               ovf       <= r_ovf;
               inexact   <= r_inexact;
               dbz       <= 1'b0;
               out_valid <= 1'b1;
            end
            ST_DONE: if (out_ready) out_valid <= 1'b0;
            default: out_valid <= 1'b0;
         endcase
      end
   end

   fxp_div_round #(
      .WIDTH (WIDTH),
      .FBITS (FBITS)
   ) u_round (
      .q         (qr),
      .rem_nz    (acc != '0),
      .is_signed (is_signed_q),
      .neg_sign  (sign_a ^ sign_b),
      .rnd       (rnd_q),
      .sat       (sat_q),
      .val_c     (r_val),
      .ovf_c     (r_ovf),
      .inexact_c (r_inexact)
   );

endmodule

// File: tb/tb_fxp_divider.sv
// Directed bench for fxp_divider at WIDTH=32, FBITS=16 with hand-computed results.
module tb_fxp_divider;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned FBITS = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             is_signed = 1'b0;
   logic             rnd = 1'b0;
   logic             sat = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] val;
   logic             dbz;
   logic             ovf;
   logic             inexact;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fxp_divider #(.WIDTH(WIDTH), .FBITS(FBITS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .is_signed (is_signed),
      .rnd       (rnd),
      .sat       (sat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .val       (val),
      .dbz       (dbz),
      .ovf       (ovf),
      .inexact   (inexact)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one request; returns after the accept edge with operand inputs scrambled.
   task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_, input logic ts,
                           input logic tr, input logic tsat);
      @(negedge clk);
      a = ta; b = tb_; is_signed = ts; rnd = tr; sat = tsat; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 32'hDEAD_BEEF; b = 32'h0; is_signed = ~ts; rnd = ~tr; sat = ~tsat;
   endtask

   // lat = clock edges after the accept edge until out_valid is seen.
   task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                         input logic ts, input logic tr, input logic tsat,
                         input logic [31:0] e_val, input logic e_dbz, input logic e_ovf,
                         input logic e_inx, input int e_lat, input int hold);
      int lat;
      start_op(ta, tb_, ts, tr, tsat);
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'(e_lat));
      chk({tag, "_val"}, 64'(val), 64'(e_val));
      chk({tag, "_flags"}, {61'b0, dbz, ovf, inexact}, {61'b0, e_dbz, e_ovf, e_inx});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, "_hold"}, {30'b0, out_valid, in_ready, val},
             {30'b0, 1'b1, 1'b0, e_val});
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_consumed"}, {62'b0, out_valid, in_ready}, {62'b0, 1'b0, 1'b1});
   endtask

   initial begin
      #12;
      chk("reset", {28'b0, out_valid, dbz, ovf, inexact, val}, 64'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_ready", 64'(in_ready), 64'h1);

      run_op("q1p5", 32'h0003_0000, 32'h0002_0000, 1'b1, 1'b0, 1'b0,
             32'h0001_8000, 1'b0, 1'b0, 1'b0, 50, 10);
      run_op("third_rne", 32'h0001_0000, 32'h0003_0000, 1'b1, 1'b1, 1'b0,
             32'h0000_5555, 1'b0, 1'b0, 1'b1, 50, 0);
      run_op("neg_third", 32'hFFFF_0000, 32'h0003_0000, 1'b1, 1'b1, 1'b0,
             32'hFFFF_AAAB, 1'b0, 1'b0, 1'b1, 50, 0);
      run_op("tie_odd_rne", 32'h0000_0003, 32'h0002_0000, 1'b1, 1'b1, 1'b0,
             32'h0000_0002, 1'b0, 1'b0, 1'b1, 50, 0);
      run_op("tie_odd_trunc", 32'h0000_0003, 32'h0002_0000, 1'b1, 1'b0, 1'b0,
             32'h0000_0001, 1'b0, 1'b0, 1'b1, 50, 0);
      run_op("tie_even_rne", 32'h0000_0001, 32'h0002_0000, 1'b1, 1'b1, 1'b0,
             32'h0000_0000, 1'b0, 1'b0, 1'b1, 50, 0);
      run_op("dbz_sat", 32'h0005_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1,
             32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 0, 0);
      run_op("dbz_nosat", 32'h0005_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0,
             32'h0000_0000, 1'b1, 1'b0, 1'b0, 0, 0);
      run_op("dbz_neg_sat", 32'hFFFB_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1,
             32'h8000_0000, 1'b1, 1'b0, 1'b0, 0, 0);
      run_op("minneg_div1", 32'h8000_0000, 32'h0001_0000, 1'b1, 1'b0, 1'b1,
             32'h8000_0000, 1'b0, 1'b0, 1'b0, 50, 0);
      run_op("minneg_divm1_sat", 32'h8000_0000, 32'hFFFF_0000, 1'b1, 1'b0, 1'b1,
             32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 50, 0);
      run_op("minneg_divm1_nosat", 32'h8000_0000, 32'hFFFF_0000, 1'b1, 1'b0, 1'b0,
             32'h0000_0000, 1'b0, 1'b1, 1'b0, 50, 0);
      run_op("uns_ovf_sat", 32'hFFFF_0000, 32'h0000_8000, 1'b0, 1'b0, 1'b1,
             32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 50, 0);
      run_op("uns_big", 32'hC000_0000, 32'h0002_0000, 1'b0, 1'b0, 1'b0,
             32'h6000_0000, 1'b0, 1'b0, 1'b0, 50, 0);

      // Reset in the middle of a calculation must abort it silently.
      start_op(32'h0003_0000, 32'h0002_0000, 1'b1, 1'b0, 1'b0);
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #3;
      chk("abort_reset", {62'b0, out_valid, in_ready}, {62'b0, 1'b0, 1'b1});
      rst_n = 1'b1;
      begin
         int seen = 0;
         for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid || !in_ready) seen++;
         end
         chk("abort_quiet", 64'(seen), 64'h0);
      end
      chk("abort_val", 64'(val), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
